regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-issue integer register file. Adds a configurable number of read ports, configurable data width and depth, an optional write-to-read bypass, and a per-register pending-write scoreboard.
- Sits between decode (reads, destination allocation) and writeback (register writes) of the RV32 core.
- Lets the hazard unit stall on operands whose producer has not yet written back.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, at least 2.
- NUM_READ, 2, number of read ports; 1 to 4.
- BYPASS, 1, 1 = a same-cycle write is visible on matching read ports; 0 = the written value appears only after the clock edge.
- ADDR_W, $clog2(NUM_REGS), register index width (derived).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- rs  in  NUM_READ*ADDR_W  read indices; port i occupies bits [i*ADDR_W +: ADDR_W].
- rs_data  out  NUM_READ*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rs_busy  out  NUM_READ  1 = operand i has an outstanding producer.
- rd  in  ADDR_W  write index.
- data  in  XLEN  write data.
- reg_write  in  1  write enable (writeback).
- issue_valid  in  1  allocate a destination at decode.
- issue_rd  in  ADDR_W  destination being allocated.
- pending_count  out  ADDR_W+1  number of registers with busy set.

Behaviour:
- Reset:
  - reset_n low asynchronously clears all registers to 0, all busy bits to 0 and pending_count to 0.
  - Outputs are valid immediately, not at the next edge.
  - Reset asserted mid-operation discards all pending state.
  - The first edge after reset_n rises acts normally.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes to index 0 are ignored.
  - Issue to index 0 is ignored and does not change pending_count.
- Write: on posedge clock with reg_write=1 and rd!=0, regs[rd] <= data.
- Read: combinational with zero latency.
  - rs_data[i] = regs[rs[i]].
  - If BYPASS=1, reg_write=1, rd!=0 and rd==rs[i], then rs_data[i] = data instead.
- rs_busy[i]:
  - Equals busy[rs[i]].
  - If BYPASS=1 and the bypass condition above holds, rs_busy[i] = 0: the value is being delivered this cycle.
  - If BYPASS=0, rs_busy[i] stays 1 until the edge has passed.
- Scoreboard update, per clock edge:
  - Clear: reg_write=1 and rd!=0 clears busy[rd]. Writes to a non-busy register are allowed and leave busy at 0.
  - Set: issue_valid=1 and issue_rd!=0 sets busy[issue_rd].
  - Same index (issue_rd==rd, both valid): set wins; busy stays 1 because a new producer now owns it.
  - Issue to an already-busy register (WAW): busy stays 1; no error.
- pending_count: popcount of busy; must always equal that popcount.
  - Updated incrementally: +1 on a 0->1 set, -1 on a 1->0 clear, net 0 when both occur on different indices.
  - Range 0..NUM_REGS-1; no wrap is possible.
- Read ports are independent. Any number may address the same register and must return the same value and busy flag.
- No X propagation: all outputs are defined for every input combination once reset has been applied.

Test Plan:
- Reset then read: assert reset_n=0 mid-cycle, rs={0,31} -> rs_data={0,0}, rs_busy=0, pending_count=0 without waiting for a clock edge.
- Basic write: rd=10, data=999, reg_write=1, one edge; then rs[0]=10, rs[1]=10 -> both read 999. Write rd=0, data=5 -> rs=0 still reads 0.
- Bypass (BYPASS=1): rd=7, data=0x1234, reg_write=1, rs[1]=7, sampled before the edge -> rs_data[1]=0x1234, rs_busy[1]=0. With BYPASS=0, the same check reads the old value (0) before the edge and 0x1234 after it.
- Scoreboard lifecycle:
  - Issue 5, then issue 6 on consecutive edges -> pending_count=2, rs_busy for 5 and 6 = 1.
  - Write 5 -> pending_count=1, busy[5]=0.
  - Issue 0 -> pending_count unchanged.
- Simultaneous events:
  - Same edge: issue_rd=9 with reg_write rd=9 while busy[9]=1 -> busy[9] stays 1, pending_count unchanged.
  - Same edge: issue_rd=3 with write rd=4 (busy[4]=1) -> busy[3]=1, busy[4]=0, count unchanged.
- Reset mid-operation: with 3 registers busy and regs holding data, pulse reset_n low between edges -> all reads 0, pending_count=0, and the next issue to 3 gives pending_count=1.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with N combinational read ports, optional
// write-to-read bypass and a per-register pending-write scoreboard for hazard stalls.
module regfile_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_READ = 2,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_READ*ADDR_W-1:0] rs,
  output logic [NUM_READ*XLEN-1:0]   rs_data,
  output logic [NUM_READ-1:0]        rs_busy,
  input  logic [ADDR_W-1:0]          rd,
  input  logic [XLEN-1:0]            data,
  input  logic                       reg_write,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_rd,
  output logic [ADDR_W:0]            pending_count
);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                wr_en, set_en, cnt_inc, cnt_dec;

  // Index 0 is hardwired: never written, never marked busy.
  assign wr_en  = reg_write && (rd != '0);
  assign set_en = issue_valid && (issue_rd != '0);

  // A set on the same index as a clear wins, so that clear must not decrement.
  assign cnt_inc = set_en && !busy_q[issue_rd];
  assign cnt_dec = wr_en && busy_q[rd] && !(set_en && (issue_rd == rd));

  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[rd]       = 1'b0;
    if (set_en) busy_d[issue_rd] = 1'b1;
    count_d = count_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) regs_q[rd] <= data;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic              hit;
    assign idx = rs[i*ADDR_W +: ADDR_W];
    assign hit = (BYPASS != 0) && wr_en && (rd == idx);
    assign rs_data[i*XLEN +: XLEN] = hit ? data : regs_q[idx];
    assign rs_busy[i]              = !hit && busy_q[idx];
  end

  assign pending_count = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: a bypassing and a non-bypassing instance share stimulus and
// are checked against a behavioural register/busy model.
module tb_regfile_scoreboard;

  logic        clock;
  logic        reset_n;
  logic [4:0]  rs0, rs1, rd, issue_rd;
  logic [31:0] data;
  logic        reg_write, issue_valid;
  logic [9:0]  rs;
  logic [63:0] rs_data_a, rs_data_b;
  logic [1:0]  rs_busy_a, rs_busy_b;
  logic [5:0]  count_a, count_b;

  assign rs = {rs1, rs0};

  regfile_scoreboard #(.XLEN(32), .NUM_REGS(32), .NUM_READ(2), .BYPASS(1)) u_dut_byp (
    .clock(clock), .reset_n(reset_n), .rs(rs), .rs_data(rs_data_a), .rs_busy(rs_busy_a),
    .rd(rd), .data(data), .reg_write(reg_write), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .pending_count(count_a));

  regfile_scoreboard #(.XLEN(32), .NUM_REGS(32), .NUM_READ(2), .BYPASS(0)) u_dut_nobyp (
    .clock(clock), .reset_n(reset_n), .rs(rs), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
    .rd(rd), .data(data), .reg_write(reg_write), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .pending_count(count_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (reg_write && rd != 0) begin
      m_regs[rd] = data;
      m_busy[rd] = 1'b0;
    end
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
  endtask

  task automatic push_expected();
    logic [4:0]  idx;
    logic [31:0] d;
    logic        bz, hit;
    int          pop;
    for (int p = 0; p < 2; p++) begin
      idx = (p == 0) ? rs0 : rs1;
      for (int b = 1; b >= 0; b--) begin
        hit = (b == 1) && reg_write && (rd != 0) && (rd == idx);
        d   = hit ? data : (idx == 0 ? 32'h0 : m_regs[idx]);
        bz  = hit ? 1'b0 : (idx == 0 ? 1'b0 : m_busy[idx]);
        exp_q.push_back('{$sformatf("data%0d_byp%0d", p, b), d});
        exp_q.push_back('{$sformatf("busy%0d_byp%0d", p, b), {31'b0, bz}});
      end
    end
    pop = 0;
    for (int r = 0; r < 32; r++) pop += int'(m_busy[r]);
    exp_q.push_back('{"count_byp1", 32'(pop)});
    exp_q.push_back('{"count_byp0", 32'(pop)});
  endtask

  task automatic compare_outputs();
    logic [31:0] obs [10];
    exp_t        e;
    obs[0] = rs_data_a[31:0];  obs[1] = {31'b0, rs_busy_a[0]};
    obs[2] = rs_data_b[31:0];  obs[3] = {31'b0, rs_busy_b[0]};
    obs[4] = rs_data_a[63:32]; obs[5] = {31'b0, rs_busy_a[1]};
    obs[6] = rs_data_b[63:32]; obs[7] = {31'b0, rs_busy_b[1]};
    obs[8] = {26'b0, count_a}; obs[9] = {26'b0, count_b};
    for (int k = 0; k < 10; k++) begin
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 32'h1, 32'h0);
        return;
      end
      e = exp_q.pop_front();
      chk(e.tag, obs[k], e.val);
    end
  endtask

  task automatic drive(input logic [4:0] r0, input logic [4:0] r1,
                       input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                       input logic iv, input logic [4:0] ird);
    rs0 = r0; rs1 = r1;
    reg_write = we; rd = wd; data = wdat;
    issue_valid = iv; issue_rd = ird;
  endtask

  // Pre-edge check of combinational outputs, then advance one edge.
  task automatic cycle();
    push_expected();
    @(negedge clock);
    compare_outputs();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    drive(r0, r1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    drive(5'd31, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    model_reset();
    #2;
    push_expected();
    compare_outputs();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Basic write and pre/post-edge visibility on both bypass flavours
    drive(5'd10, 5'd10, 1'b1, 5'd10, 32'd999, 1'b0, 5'd0); cycle();
    idle(5'd10, 5'd10);
    drive(5'd0, 5'd0, 1'b1, 5'd0, 32'd5, 1'b0, 5'd0); cycle();
    idle(5'd0, 5'd10);

    drive(5'd3, 5'd7, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0); cycle();
    idle(5'd7, 5'd7);

    // Scoreboard lifecycle
    drive(5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5); cycle();
    drive(5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6); cycle();
    idle(5'd5, 5'd6);
    drive(5'd5, 5'd6, 1'b1, 5'd5, 32'hAAAA_0005, 1'b0, 5'd0); cycle();
    idle(5'd5, 5'd6);
    drive(5'd0, 5'd6, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0); cycle();
    idle(5'd0, 5'd6);

    // Simultaneous set/clear on same and different indices, WAW, write to idle reg
    drive(5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9); cycle();
    drive(5'd9, 5'd9, 1'b1, 5'd9, 32'd77, 1'b1, 5'd9); cycle();
    idle(5'd9, 5'd9);
    drive(5'd4, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4); cycle();
    drive(5'd3, 5'd4, 1'b1, 5'd4, 32'h4444, 1'b1, 5'd3); cycle();
    idle(5'd3, 5'd4);
    drive(5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3); cycle();
    drive(5'd12, 5'd3, 1'b1, 5'd12, 32'hC0FFEE, 1'b0, 5'd0); cycle();
    idle(5'd12, 5'd3);

    for (int n = 0; n < 300; n++) begin
      logic [4:0] w, a, b;
      w = 5'($urandom_range(0, 31));
      a = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
      drive(a, b, 1'($urandom_range(0, 1)), w, $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      cycle();
    end

    // Mid-cycle reset with busy registers and live data
    drive(5'd3, 5'd3, 1'b1, 5'd20, 32'h2020, 1'b1, 5'd3); cycle();
    drive(5'd21, 5'd3, 1'b1, 5'd21, 32'h2121, 1'b1, 5'd21); cycle();
    drive(5'd22, 5'd20, 1'b0, 5'd0, 32'h0, 1'b1, 5'd22); cycle();
    idle(5'd20, 5'd21);
    drive(5'd3, 5'd20, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    reset_n = 1'b0;
    model_reset();
    #1;
    push_expected();
    compare_outputs();
    #1;
    reset_n = 1'b1;
    drive(5'd3, 5'd21, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3); cycle();
    idle(5'd3, 5'd21);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
